// File: rtl/uart_frame_ctrl.sv
// Receive-side command-frame assembler: HEADER, ADDR, DATA_H, DATA_L (+ CHK when
// FRAME_CHKSUM_EN is defined) -> one-cycle register write strobe; bad/stalled frames counted.
module uart_frame_ctrl #(
   parameter logic [7:0] HEADER      = 8'hAA,
   parameter int         TIMEOUT_MAX = 208_320
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [7:0]  pi_data,
   input  logic        pi_flag,
   output logic        reg_wr_en,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wr_data,
   output logic        frame_err,
   output logic [7:0]  err_cnt,
   output logic        busy,
   output logic [2:0]  state_dbg
);

   localparam int              TO_W    = $clog2(TIMEOUT_MAX + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      DATH = 3'd2,
      DATL = 3'd3
`ifdef FRAME_CHKSUM_EN
      , CHK = 3'd4
`endif
   } state_t;

   state_t          state, state_nxt;
   logic [TO_W-1:0] timer;
   logic [7:0]      addr_q, dath_q;
   logic            commit, err_det, timeout;
   logic [15:0]     wr_data_nxt;
`ifdef FRAME_CHKSUM_EN
   logic [7:0]      datl_q, chk_sum;
`endif

   assign state_dbg = state;

   // A byte arriving on the last timer count wins over the timeout.
   assign timeout = (state != IDLE) && !pi_flag && (timer == TO_LAST);

`ifdef FRAME_CHKSUM_EN
   assign wr_data_nxt = {dath_q, datl_q};
`else
   assign wr_data_nxt = {dath_q, pi_data};
`endif

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      err_det   = 1'b0;
      case (state)
         IDLE: if (pi_flag && pi_data == HEADER) state_nxt = ADDR;
         ADDR: if (pi_flag) state_nxt = DATH;
         DATH: if (pi_flag) state_nxt = DATL;
         DATL: begin
            if (pi_flag) begin
`ifdef FRAME_CHKSUM_EN
               state_nxt = CHK;
`else
               state_nxt = IDLE;
               commit    = 1'b1;
`endif
            end
         end
`ifdef FRAME_CHKSUM_EN
         CHK: begin
            if (pi_flag) begin
               state_nxt = IDLE;
               if (pi_data == chk_sum) commit  = 1'b1;
               else                    err_det = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
      if (timeout) begin
         state_nxt = IDLE;
         err_det   = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         addr_q      <= 8'd0;
         dath_q      <= 8'd0;
         reg_wr_en   <= 1'b0;
         reg_addr    <= 8'd0;
         reg_wr_data <= 16'd0;
         frame_err   <= 1'b0;
         err_cnt     <= 8'd0;
         busy        <= 1'b0;
      end else begin
         state     <= state_nxt;
         busy      <= (state_nxt != IDLE);
         reg_wr_en <= commit;
         frame_err <= err_det;

         if (pi_flag || state == IDLE || timeout) timer <= '0;
         else                                     timer <= timer + 1'b1;

         if (pi_flag && state == ADDR) addr_q <= pi_data;
         if (pi_flag && state == DATH) dath_q <= pi_data;

         if (commit) begin
            reg_addr    <= addr_q;
            reg_wr_data <= wr_data_nxt;
         end

         if (err_det && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

`ifdef FRAME_CHKSUM_EN
   // Running 8-bit sum of ADDR, DATA_H, DATA_L; restarts with the address byte.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         datl_q  <= 8'd0;
         chk_sum <= 8'd0;
      end else if (pi_flag) begin
         case (state)
            ADDR: chk_sum <= pi_data;
            DATH: chk_sum <= chk_sum + pi_data;
            DATL: begin
               chk_sum <= chk_sum + pi_data;
               datl_q  <= pi_data;
            end
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl with a short timeout so stall and saturation cases run quickly.
module tb_uart_frame_ctrl;

   localparam int T = 20;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [7:0]  pi_data;
   logic        pi_flag;
   logic        reg_wr_en;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wr_data;
   logic        frame_err;
   logic [7:0]  err_cnt;
   logic        busy;
   logic [2:0]  state_dbg;

   uart_frame_ctrl #(.HEADER(8'hAA), .TIMEOUT_MAX(T)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .pi_data     (pi_data),
      .pi_flag     (pi_flag),
      .reg_wr_en   (reg_wr_en),
      .reg_addr    (reg_addr),
      .reg_wr_data (reg_wr_data),
      .frame_err   (frame_err),
      .err_cnt     (err_cnt),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [7:0]  addr;
      logic [7:0]  dh;
      logic [7:0]  dl;
      logic [7:0]  chk_delta;
      logic        exp_wr;
      logic [7:0]  exp_addr;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[$];
   vec_t        v;
   logic [23:0] exp_q[$];
   logic [23:0] mon_exp;
   logic [7:0]  fb[5];
   int          nb;
   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_err_cnt = 0;
   int          err_pulses = 0;
   int          exp_err_pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_err();
      exp_err_pulses++;
      if (exp_err_cnt < 255) exp_err_cnt++;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Called at a negedge; returns at the next negedge, one cycle after the DUT sampled the byte.
   task automatic send_byte(input logic [7:0] b);
      pi_data = b;
      pi_flag = 1'b1;
      @(negedge sys_clk);
      pi_flag = 1'b0;
      pi_data = 8'($urandom_range(0, 255));
   endtask

   task automatic build_frame(input vec_t fv);
      fb[0] = 8'hAA;
      fb[1] = fv.addr;
      fb[2] = fv.dh;
      fb[3] = fv.dl;
      fb[4] = fv.addr + fv.dh + fv.dl + fv.chk_delta;
`ifdef FRAME_CHKSUM_EN
      nb = 5;
`else
      nb = 4;
`endif
   endtask

   task automatic send_frame(input vec_t fv, input int gap);
      build_frame(fv);
      for (int i = 0; i < nb; i++) begin
         if (i == nb - 1 && fv.exp_wr) exp_q.push_back({fv.exp_addr, fv.exp_data});
         send_byte(fb[i]);
         if (i != nb - 1) idle(gap);
      end
      if (fv.exp_err) note_err();
      check("wr_en_after_last", reg_wr_en, fv.exp_wr);
      check("frame_err_after_last", frame_err, fv.exp_err);
      check("reg_addr", reg_addr, fv.exp_addr);
      check("reg_wr_data", reg_wr_data, fv.exp_data);
      check("busy_after_frame", busy, 1'b0);
      check("err_cnt", err_cnt, exp_err_cnt);
      @(negedge sys_clk);
      check("wr_en_one_cycle", reg_wr_en, 1'b0);
      check("frame_err_one_cycle", frame_err, 1'b0);
   endtask

   always @(negedge sys_clk) begin
      if (frame_err === 1'b1) err_pulses++;
      if (reg_wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                     reg_addr, reg_wr_data, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("wr_scoreboard", {reg_addr, reg_wr_data}, mon_exp);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no end of test expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs.push_back('{8'h10, 8'h12, 8'h34, 8'h00, 1'b1, 8'h10, 16'h1234, 1'b0});
      vecs.push_back('{8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 8'hFF, 16'hFFFF, 1'b0});
      vecs.push_back('{8'h00, 8'hAA, 8'h00, 8'h00, 1'b1, 8'h00, 16'hAA00, 1'b0});
      vecs.push_back('{8'hAA, 8'hAA, 8'hAA, 8'h00, 1'b1, 8'hAA, 16'hAAAA, 1'b0});
      vecs.push_back('{8'h5A, 8'h00, 8'h01, 8'h00, 1'b1, 8'h5A, 16'h0001, 1'b0});
`ifdef FRAME_CHKSUM_EN
      vecs.push_back('{8'h10, 8'h12, 8'h34, 8'h01, 1'b0, 8'h5A, 16'h0001, 1'b1});
`endif
      vecs.push_back('{8'h20, 8'h30, 8'h40, 8'h00, 1'b1, 8'h20, 16'h3040, 1'b0});

      // Clock/reset
      sys_rst_n = 1'b0;
      pi_flag   = 1'b0;
      pi_data   = 8'h00;
      idle(3);
      check("rst_wr_en", reg_wr_en, 1'b0);
      check("rst_addr", reg_addr, 8'h00);
      check("rst_data", reg_wr_data, 16'h0000);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_err_cnt", err_cnt, 8'h00);
      check("rst_busy", busy, 1'b0);
      sys_rst_n = 1'b1;
      idle(2);

      // Leading junk bytes are ignored without error
      send_byte(8'h00); check("junk_busy0", busy, 1'b0); idle(2);
      send_byte(8'hFF); check("junk_busy1", busy, 1'b0); idle(2);
      send_byte(8'h55); check("junk_busy2", busy, 1'b0); idle(2);
      v = '{8'h01, 8'h00, 8'h02, 8'h00, 1'b1, 8'h01, 16'h0002, 1'b0};
      send_frame(v, 3);
      check("junk_err_cnt_zero", err_cnt, 8'h00);

      // Table
      for (int i = 0; i < vecs.size(); i++) begin
         send_frame(vecs[i], 3);
         idle(2);
      end

      // Timeout after HEADER, ADDR
      send_byte(8'hAA);
      send_byte(8'h10);
      idle(T - 1);
      check("to_busy_before", busy, 1'b1);
      check("to_err_before", frame_err, 1'b0);
      idle(1);
      note_err();
      check("to_busy_after", busy, 1'b0);
      check("to_err_pulse", frame_err, 1'b1);
      check("to_err_cnt", err_cnt, exp_err_cnt);
      idle(1);
      check("to_err_one_cycle", frame_err, 1'b0);
      v = '{8'h33, 8'h44, 8'h55, 8'h00, 1'b1, 8'h33, 16'h4455, 1'b0};
      send_frame(v, 3);

      // Byte arriving exactly when timer == TIMEOUT_MAX-1 is accepted
      v = '{8'h77, 8'h88, 8'h99, 8'h00, 1'b1, 8'h77, 16'h8899, 1'b0};
      send_frame(v, T - 1);
      idle(2);

      // Saturation of err_cnt
      for (int i = 0; i < 260; i++) begin
         send_byte(8'hAA);
         idle(T);
         note_err();
         check("sat_err_cnt", err_cnt, exp_err_cnt);
      end
      check("sat_at_255", err_cnt, 8'hFF);

      // Reset mid-frame
      send_byte(8'hAA); idle(2);
      send_byte(8'h10); idle(2);
      sys_rst_n = 1'b0;
      #1;
      exp_err_cnt = 0;
      check("mid_rst_err_cnt", err_cnt, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_wr_en", reg_wr_en, 1'b0);
      check("mid_rst_addr", reg_addr, 8'h00);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle(1);
      send_byte(8'h12); check("post_rst_busy", busy, 1'b0); idle(2);
      send_byte(8'h34); check("post_rst_wr_en", reg_wr_en, 1'b0);
      idle(T + 5);
      check("post_rst_err_cnt", err_cnt, 8'h00);
      check("post_rst_busy_idle", busy, 1'b0);
      v = '{8'hC3, 8'h5A, 8'hA5, 8'h00, 1'b1, 8'hC3, 16'h5AA5, 1'b0};
      send_frame(v, 3);
      idle(3);

      check("scoreboard_drained", exp_q.size(), 0);
      check("err_pulse_total", err_pulses, exp_err_pulses);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
